fft_magnitude_pipe: RTL and testbench

//  Parametrised successor to the FFT modulus stage. Converts a stream of signed complex FFT bins
//  to unsigned magnitude, either exact (pipelined integer sqrt) or alpha-max-beta-min approximation.

---
 rtl/fft_magnitude_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_fft_magnitude_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_magnitude_pipe.sv
// Complex FFT bin -> unsigned magnitude (exact pipelined sqrt or alpha-max-beta-min), with
// sop/eop/valid forwarded at a fixed latency and a per-frame peak tracker on the output side.
module fft_magnitude_pipe #(
    parameter int DW        = 16,
    parameter int MODE      = 0,
    parameter int FRAME_LEN = 128,
    localparam int IW       = $clog2(FRAME_LEN)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [DW-1:0] source_real,
    input  logic [DW-1:0] source_imag,
    input  logic          source_sop,
    input  logic          source_eop,
    input  logic          source_valid,
    output logic [DW-1:0] data_modulus,
    output logic          data_sop,
    output logic          data_eop,
    output logic          data_valid,
    output logic [DW-1:0] peak_value,
    output logic [IW-1:0] peak_index,
    output logic          peak_valid,
    output logic          frame_err
);
    localparam int LAT = (MODE == 0) ? DW + 2 : 3;
    localparam logic [DW-1:0] ONE_DW   = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] ONE_IW   = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    logic [LAT-1:0] vld_pipe_d, vld_pipe_q;
    logic [LAT-1:0] sop_pipe_d, sop_pipe_q;
    logic [LAT-1:0] eop_pipe_d, eop_pipe_q;
    logic [DW-1:0]  abs_re_d, abs_re_q;
    logic [DW-1:0]  abs_im_d, abs_im_q;
    logic [DW-1:0]  mod_out;

    // Stage 1: two's complement negate; the most negative input lands on 2^(DW-1) unsigned.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[LAT-2:0], source_valid};
        sop_pipe_d = {sop_pipe_q[LAT-2:0], source_sop};
        eop_pipe_d = {eop_pipe_q[LAT-2:0], source_eop};
        abs_re_d   = source_real[DW-1] ? (~source_real + ONE_DW) : source_real;
        abs_im_d   = source_imag[DW-1] ? (~source_imag + ONE_DW) : source_imag;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vld_pipe_q <= '0;
            sop_pipe_q <= '0;
            eop_pipe_q <= '0;
            abs_re_q   <= '0;
            abs_im_q   <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            sop_pipe_q <= sop_pipe_d;
            eop_pipe_q <= eop_pipe_d;
            abs_re_q   <= abs_re_d;
            abs_im_q   <= abs_im_d;
        end
    end

    generate
        if (MODE == 0) begin : g_exact
            localparam logic [2*DW-1:0] ONE_2DW = {{(2*DW-1){1'b0}}, 1'b1};
            // Index 0 holds the squared sum; index k resolves root bit DW-k from remainder k-1.
            logic [2*DW-1:0] rem_d  [DW+1];
            logic [2*DW-1:0] rem_q  [DW+1];
            logic [DW-1:0]   root_d [DW+1];
            logic [DW-1:0]   root_q [DW+1];

            always_comb begin
                logic [2*DW-1:0] delta;
                rem_d     = rem_q;
                root_d    = root_q;
                delta     = '0;
                rem_d[0]  = {{DW{1'b0}}, abs_re_q} * {{DW{1'b0}}, abs_re_q}
                          + {{DW{1'b0}}, abs_im_q} * {{DW{1'b0}}, abs_im_q};
                root_d[0] = '0;
                for (int k = 1; k <= DW; k++) begin
                    // (root + 2^b)^2 - root^2 = root*2^(b+1) + 2^(2b), with b = DW-k
                    delta = ({{DW{1'b0}}, root_q[k-1]} << (DW - k + 1))
                          + (ONE_2DW << (2 * (DW - k)));
                    if (rem_q[k-1] >= delta) begin
                        rem_d[k]  = rem_q[k-1] - delta;
                        root_d[k] = root_q[k-1] | (ONE_DW << (DW - k));
                    end else begin
                        rem_d[k]  = rem_q[k-1];
                        root_d[k] = root_q[k-1];
                    end
                end
            end

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    for (int k = 0; k <= DW; k++) begin
                        rem_q[k]  <= '0;
                        root_q[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k <= DW; k++) begin
                        rem_q[k]  <= rem_d[k];
                        root_q[k] <= root_d[k];
                    end
                end
            end

            assign mod_out = root_q[DW];
        end else begin : g_approx
            logic [DW-1:0] mx_d, mx_q;
            logic [DW-1:0] mn_d, mn_q;
            logic [DW-1:0] mag_d, mag_q;
            logic [DW:0]   sum_w;

            always_comb begin
                mx_d  = (abs_re_q >= abs_im_q) ? abs_re_q : abs_im_q;
                mn_d  = (abs_re_q >= abs_im_q) ? abs_im_q : abs_re_q;
                sum_w = {1'b0, mx_q} + {1'b0, mn_q >> 2} + {1'b0, mn_q >> 3};
                mag_d = sum_w[DW] ? {DW{1'b1}} : sum_w[DW-1:0];
            end

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    mx_q  <= '0;
                    mn_q  <= '0;
                    mag_q <= '0;
                end else begin
                    mx_q  <= mx_d;
                    mn_q  <= mn_d;
                    mag_q <= mag_d;
                end
            end

            assign mod_out = mag_q;
        end
    endgenerate

    assign data_modulus = mod_out;
    assign data_valid   = vld_pipe_q[LAT-1];
    assign data_sop     = sop_pipe_q[LAT-1];
    assign data_eop     = eop_pipe_q[LAT-1];

    logic          open_d, open_q;
    logic          restart_d, restart_q;
    logic [IW-1:0] bin_d, bin_q;
    logic [DW-1:0] max_d, max_q;
    logic [IW-1:0] max_idx_d, max_idx_q;
    logic [DW-1:0] peak_value_d, peak_value_q;
    logic [IW-1:0] peak_index_d, peak_index_q;
    logic          peak_valid_d, peak_valid_q;
    logic          frame_err_d, frame_err_q;

    // Tracker sees only output-side beats; strict '>' keeps the lowest index on ties.
    always_comb begin
        open_d       = open_q;
        restart_d    = restart_q;
        bin_d        = bin_q;
        max_d        = max_q;
        max_idx_d    = max_idx_q;
        peak_value_d = peak_value_q;
        peak_index_d = peak_index_q;
        frame_err_d  = frame_err_q;
        peak_valid_d = 1'b0;
        if (data_valid) begin
            if (data_sop) begin
                open_d    = 1'b1;
                restart_d = open_q;
                bin_d     = '0;
                max_d     = mod_out;
                max_idx_d = '0;
            end else if (open_q) begin
                bin_d = bin_q + ONE_IW;
                if (mod_out > max_q) begin
                    max_d     = mod_out;
                    max_idx_d = bin_q + ONE_IW;
                end
            end
            if (data_eop && (open_q || data_sop)) begin
                open_d       = 1'b0;
                peak_value_d = max_d;
                peak_index_d = max_idx_d;
                frame_err_d  = restart_d || (bin_d != LAST_IDX);
                peak_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            open_q       <= 1'b0;
            restart_q    <= 1'b0;
            bin_q        <= '0;
            max_q        <= '0;
            max_idx_q    <= '0;
            peak_value_q <= '0;
            peak_index_q <= '0;
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            open_q       <= open_d;
            restart_q    <= restart_d;
            bin_q        <= bin_d;
            max_q        <= max_d;
            max_idx_q    <= max_idx_d;
            peak_value_q <= peak_value_d;
            peak_index_q <= peak_index_d;
            peak_valid_q <= peak_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign peak_value = peak_value_q;
    assign peak_index = peak_index_q;
    assign peak_valid = peak_valid_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_fft_magnitude_pipe.sv
// Bench for fft_magnitude_pipe: exact (MODE 0) and approximate (MODE 1) instances share one
// stimulus stream; expected beats and frame peaks are queued at issue and popped by monitors.
module tb_fft_magnitude_pipe;
    localparam int DW   = 16;
    localparam int FL   = 128;
    localparam int IW   = 7;
    localparam int LAT0 = DW + 2;
    localparam int LAT1 = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] re = '0, im = '0;
    logic          sop = 1'b0, eop = 1'b0, vld = 1'b0;

    logic [DW-1:0] mod0, mod1, pv0, pv1;
    logic [IW-1:0] pi0, pi1;
    logic          sop0, eop0, vo0, pkv0, fe0;
    logic          sop1, eop1, vo1, pkv1, fe1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pk_seen0 = 0, pk_seen1 = 0;
    logic prev_eop0 = 1'b0, prev_eop1 = 1'b0;

    logic [DW-1:0] exp0_q[$], exp1_q[$];
    int            cyc0_q[$], cyc1_q[$];
    logic [23:0]   pk0_q[$], pk1_q[$];

    fft_magnitude_pipe #(.DW(DW), .MODE(0), .FRAME_LEN(FL)) dut0 (
        .sys_clk(clk), .sys_rst(rst), .source_real(re), .source_imag(im),
        .source_sop(sop), .source_eop(eop), .source_valid(vld),
        .data_modulus(mod0), .data_sop(sop0), .data_eop(eop0), .data_valid(vo0),
        .peak_value(pv0), .peak_index(pi0), .peak_valid(pkv0), .frame_err(fe0)
    );

    fft_magnitude_pipe #(.DW(DW), .MODE(1), .FRAME_LEN(FL)) dut1 (
        .sys_clk(clk), .sys_rst(rst), .source_real(re), .source_imag(im),
        .source_sop(sop), .source_eop(eop), .source_valid(vld),
        .data_modulus(mod1), .data_sop(sop1), .data_eop(eop1), .data_valid(vo1),
        .peak_value(pv1), .peak_index(pi1), .peak_valid(pkv1), .frame_err(fe1)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got unexpected output expected none", name);
    endtask

    function automatic logic [DW-1:0] ref_exact(input logic [DW-1:0] r, input logic [DW-1:0] i);
        longint a, b, s, lo, hi, mid;
        a  = longint'($signed(r));
        b  = longint'($signed(i));
        s  = a * a + b * b;
        lo = 0;
        hi = 65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= s) lo = mid;
            else hi = mid;
        end
        return DW'(lo);
    endfunction

    function automatic logic [DW-1:0] ref_approx(input logic [DW-1:0] r, input logic [DW-1:0] i);
        longint a, b, mx, mn, v;
        a  = longint'($signed(r));
        b  = longint'($signed(i));
        a  = (a < 0) ? -a : a;
        b  = (b < 0) ? -b : b;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        v  = mx + mn / 4 + mn / 8;
        if (v > 65535) v = 65535;
        return DW'(v);
    endfunction

    // Driver tasks
    task automatic drive(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic s,
                         input logic e, input logic v, input logic [DW-1:0] x0,
                         input logic [DW-1:0] x1);
        re  = r;
        im  = i;
        sop = s;
        eop = e;
        vld = v;
        if (v) begin
            exp0_q.push_back(x0);
            exp1_q.push_back(x1);
            cyc0_q.push_back(cyc);
            cyc1_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0, '0);
    endtask

    task automatic flush_all();
        exp0_q.delete();
        exp1_q.delete();
        cyc0_q.delete();
        cyc1_q.delete();
        pk0_q.delete();
        pk1_q.delete();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        vld = 1'b0;
        sop = 1'b0;
        eop = 1'b0;
        flush_all();
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        check("rst_out0", {mod0, sop0, eop0, vo0, pv0, pi0, pkv0, fe0}, 64'd0);
        check("rst_out1", {mod1, sop1, eop1, vo1, pv1, pi1, pkv1, fe1}, 64'd0);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n   = 0;
        vld = 1'b0;
        sop = 1'b0;
        eop = 1'b0;
        while ((exp0_q.size() + exp1_q.size() + pk0_q.size() + pk1_q.size()) != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", exp0_q.size() + exp1_q.size() + pk0_q.size() + pk1_q.size(), 64'd0);
    endtask

    task automatic push_peak(input logic err, input int idx, input logic [DW-1:0] val);
        pk0_q.push_back({err, 7'(idx), val});
        pk1_q.push_back({err, 7'(idx), val});
    endtask

    // Bin k carries (k,0), so both modes produce magnitude k.
    task automatic lin_frame(input int len, input int resop_at, input bit spikes);
        logic [DW-1:0] v;
        for (int k = 0; k < len; k++) begin
            v = 16'(k);
            if (spikes && (k == 40 || k == 90)) v = 16'd5000;
            drive(v, '0, (k == 0) || (k == resop_at), k == len - 1, 1'b1, v, v);
        end
    endtask

    task automatic rand_frame(input int n_bins, input bit close);
        logic [DW-1:0] r, i, m0, m1, best0, best1;
        int idx0, idx1, gaps;
        best0 = '0;
        best1 = '0;
        idx0  = 0;
        idx1  = 0;
        for (int k = 0; k < n_bins; k++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) idle();
            r  = 16'($urandom_range(0, 65535));
            i  = 16'($urandom_range(0, 65535));
            m0 = ref_exact(r, i);
            m1 = ref_approx(r, i);
            if (k == 0 || m0 > best0) begin best0 = m0; idx0 = k; end
            if (k == 0 || m1 > best1) begin best1 = m1; idx1 = k; end
            if (close && k == n_bins - 1) begin
                pk0_q.push_back({1'b0, 7'(idx0), best0});
                pk1_q.push_back({1'b0, 7'(idx1), best1});
            end
            drive(r, i, k == 0, close && (k == n_bins - 1), 1'b1, m0, m1);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (!rst) begin
            if (vo0) begin
                if (exp0_q.size() == 0) fail_now("unexpected_valid0");
                else begin
                    check("mod0", mod0, exp0_q.pop_front());
                    check("lat0", cyc - cyc0_q.pop_front(), LAT0);
                end
            end
            if (vo1) begin
                if (exp1_q.size() == 0) fail_now("unexpected_valid1");
                else begin
                    check("mod1", mod1, exp1_q.pop_front());
                    check("lat1", cyc - cyc1_q.pop_front(), LAT1);
                end
            end
            if (pkv0) begin
                pk_seen0++;
                check("peak_after_eop0", prev_eop0, 1);
                if (pk0_q.size() == 0) fail_now("unexpected_peak0");
                else check("peak0", {fe0, pi0, pv0}, pk0_q.pop_front());
            end
            if (pkv1) begin
                pk_seen1++;
                check("peak_after_eop1", prev_eop1, 1);
                if (pk1_q.size() == 0) fail_now("unexpected_peak1");
                else check("peak1", {fe1, pi1, pv1}, pk1_q.pop_front());
            end
            prev_eop0 = vo0 & eop0;
            prev_eop1 = vo1 & eop1;
        end else begin
            prev_eop0 = 1'b0;
            prev_eop1 = 1'b0;
        end
    end

    logic [DW-1:0] tv_re [8];
    logic [DW-1:0] tv_im [8];
    logic [DW-1:0] tv_e0 [8];
    logic [DW-1:0] tv_e1 [8];
    int saved0, saved1;

    initial begin
        tv_re = '{16'd3,    16'h8000, 16'd32767, 16'd0, 16'd100,  16'd1000, 16'hFFF9, 16'hFFFF};
        tv_im = '{16'hFFFC, 16'h8000, 16'd0,     16'd0, 16'hFF9C, 16'hF830, 16'd24,   16'd0};
        tv_e0 = '{16'd5,    16'd46340, 16'd32767, 16'd0, 16'd141, 16'd2236, 16'd25,   16'd1};
        tv_e1 = '{16'd4,    16'd45056, 16'd32767, 16'd0, 16'd137, 16'd2375, 16'd25,   16'd1};

        do_reset(2);

        for (int t = 0; t < 8; t++) begin
            drive(tv_re[t], tv_im[t], 1'b0, 1'b0, 1'b1, tv_e0[t], tv_e1[t]);
            if (t % 2 == 1) idle();
        end
        drain();

        push_peak(1'b0, 40, 16'd5000);
        lin_frame(128, -1, 1'b1);
        drain();

        push_peak(1'b1, 99, 16'd99);
        lin_frame(100, -1, 1'b0);
        push_peak(1'b1, 117, 16'd127);
        lin_frame(128, 10, 1'b0);
        drain();

        push_peak(1'b1, 0, 16'd7);
        drive(16'd7, '0, 1'b1, 1'b1, 1'b1, 16'd7, 16'd7);
        drain();

        rand_frame(128, 1'b1);
        drain();
        rand_frame(128, 1'b1);
        drain();

        rand_frame(50, 1'b0);
        do_reset(1);
        saved0 = pk_seen0;
        saved1 = pk_seen1;
        drive(16'd9, '0, 1'b0, 1'b1, 1'b1, 16'd9, 16'd9);
        idle();
        drain();
        check("orphan_eop0", pk_seen0, saved0);
        check("orphan_eop1", pk_seen1, saved1);

        rand_frame(128, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
